mem_stage: RTL

Memory-access stage controller of the pipelined LC-3b datapath, between the EX/MEM latch and the MEM/WB latch. It decodes the opcode of the instruction held in EX/MEM and runs the data-memory handshake. This covers word and byte loads and stores, the two-access indirect forms (LDI/STI), and the TRAP vector fetch. It produces the 16-bit MDR value for the MEM/WB latch and a stall that freezes every pipeline latch until the access completes.

---
 rtl/mem_stage.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: LC-3b memory-access stage controller (EX/MEM -> MEM/WB).
// Decodes the EX/MEM opcode, runs the data-memory handshake for word/byte
// loads and stores, the LDI/STI indirect forms and the TRAP vector fetch,
// and produces the MDR value plus a pipeline stall.
// Optional feature macro: MEM_STAGE_STALL_CNT_EN adds the stall_count output.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [3:0]  opcode,
  input  logic [15:0] alu_in,
  input  logic [15:0] src_data,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_byte_enable,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [15:0] mdr_out,
`ifdef MEM_STAGE_STALL_CNT_EN
  output logic [15:0] stall_count,
`endif
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PTR    = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  state_t      state_q, state_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] ptr_q, ptr_d;
  logic        is_load_s, is_store_s, is_trap_s, is_ind_s, is_byte_s;
  logic        mem_op_s;

  // Pick the addressed byte of a word and sign-extend it to 16 bits.
  function automatic logic [15:0] sext_byte(input logic [15:0] word, input logic hi);
    logic [7:0] b;
    b = hi ? word[15:8] : word[7:0];
    return {{8{b[7]}}, b};
  endfunction

  // Decode the EX/MEM opcode into its memory-access class.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    is_trap_s  = 1'b0;
    is_ind_s   = 1'b0;
    is_byte_s  = 1'b0;
    case (opcode)
      OP_LDB:  begin is_load_s  = 1'b1; is_byte_s = 1'b1; end
      OP_LDR:  is_load_s = 1'b1;
      OP_LDI:  begin is_load_s  = 1'b1; is_ind_s  = 1'b1; end
      OP_STB:  begin is_store_s = 1'b1; is_byte_s = 1'b1; end
      OP_STR:  is_store_s = 1'b1;
      OP_STI:  begin is_store_s = 1'b1; is_ind_s  = 1'b1; end
      OP_TRAP: is_trap_s = 1'b1;
      default: is_load_s = 1'b0;
    endcase
    mem_op_s = valid_in & (is_load_s | is_store_s | is_trap_s);
  end

  // Next state, indirect pointer capture and MDR capture on the final response.
  // Losing the live memory op mid-access drops back to IDLE without a result.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mdr_d   = mdr_q;
    case (state_q)
      IDLE: begin
        if (mem_op_s) begin
          state_d = is_ind_s ? PTR : ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      PTR: begin
        if (!mem_op_s) begin
          state_d = IDLE;
        end else if (dmem_resp) begin
          ptr_d   = dmem_rdata;
          state_d = ACCESS;
        end else begin
          state_d = PTR;
        end
      end
      ACCESS: begin
        if (!mem_op_s) begin
          state_d = IDLE;
        end else if (dmem_resp) begin
          if (is_load_s | is_trap_s) begin
            mdr_d = is_byte_s ? sext_byte(dmem_rdata, alu_in[0]) : dmem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
          state_d = DONE;
        end else begin
          state_d = ACCESS;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory request drive, combinational from state and the held EX/MEM inputs.
  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = 16'h0000;
    dmem_wdata       = 16'h0000;
    dmem_byte_enable = 2'b00;
    if (mem_op_s && (state_q == PTR)) begin
      dmem_read        = 1'b1;
      dmem_address     = {alu_in[15:1], 1'b0};
      dmem_byte_enable = 2'b11;
    end else if (mem_op_s && (state_q == ACCESS)) begin
      dmem_read  = is_load_s | is_trap_s;
      dmem_write = is_store_s;
      if (is_byte_s) begin
        dmem_address     = alu_in;
        dmem_byte_enable = alu_in[0] ? 2'b10 : 2'b01;
        dmem_wdata       = {src_data[7:0], src_data[7:0]};
      end else begin
        dmem_address     = is_ind_s ? {ptr_q[15:1], 1'b0} : {alu_in[15:1], 1'b0};
        dmem_byte_enable = 2'b11;
        dmem_wdata       = src_data;
      end
    end else begin
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
    end
  end

  // State, pointer and MDR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mdr_q   <= mdr_d;
    end
  end

  assign stall   = mem_op_s & (state_q != DONE);
  assign mdr_out = mdr_q;

`ifdef MEM_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Stall-cycle counter increment; wraps from 0xFFFF to 0x0000.
  always_comb begin
    if (stall) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall-cycle counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule
